// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle data-memory access stage. Drives a req/gnt/rvalid
//               word bus with byte strobes and returns extended load data.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_req_valid,
    input  logic        lsu_req_write,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_ready,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_error,
    output logic [1:0]  lsu_err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_ERR_MISALIGN = 2'b01;
    localparam logic [1:0] c_ERR_FUNCT3   = 2'b10;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_RESP = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic               r_write;
    logic [2:0]         r_funct3;
    logic [1:0]         r_lane;
    logic [1:0]         r_err_code;
    logic [c_TMO_W-1:0] r_tmo;
    logic [31:0]        r_rdata;
    logic [31:0]        r_mem_addr;
    logic               r_mem_we;
    logic [31:0]        r_mem_wdata;
    logic [3:0]         r_mem_wstrb;

    logic        w_illegal;
    logic        w_misaligned;
    logic        w_tmo_hit;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_fmt;

    // Request decode, evaluated on the incoming core request while idle.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        case (lsu_funct3)
            3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
            3'b100, 3'b101:         w_illegal = lsu_req_write;
            default:                w_illegal = 1'b1;
        endcase
        case (lsu_funct3)
            3'b001, 3'b101: w_misaligned = lsu_addr[0];
            3'b010:         w_misaligned = |lsu_addr[1:0];
            default:        w_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        w_st_wdata = lsu_wdata;
        w_st_wstrb = 4'b1111;
        case (lsu_funct3[1:0])
            2'b00: begin
                w_st_wdata = {4{lsu_wdata[7:0]}};
                w_st_wstrb = 4'b0001 << lsu_addr[1:0];
            end
            2'b01: begin
                w_st_wdata = {2{lsu_wdata[15:0]}};
                w_st_wstrb = lsu_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_st_wdata = lsu_wdata;
                w_st_wstrb = 4'b1111;
            end
        endcase
    end

    // Lane extraction uses the byte offset captured at accept time.
    always_comb begin
        w_byte     = mem_rdata[{r_lane, 3'b000} +: 8];
        w_half     = mem_rdata[{r_lane[1], 4'b0000} +: 16];
        w_load_fmt = mem_rdata;
        case (r_funct3)
            3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_fmt = {24'h000000, w_byte};
            3'b101:  w_load_fmt = {16'h0000, w_half};
            default: w_load_fmt = mem_rdata;
        endcase
    end

    assign w_tmo_hit = (r_tmo >= c_TMO_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (lsu_req_valid) begin
                    w_next_state = (w_illegal || w_misaligned) ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    w_next_state = S_WAIT;
                end else if (w_tmo_hit) begin
                    w_next_state = S_ERR;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_next_state = S_RESP;
                end else if (w_tmo_hit) begin
                    w_next_state = S_ERR;
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_funct3    <= 3'b000;
            r_lane      <= 2'b00;
            r_err_code  <= 2'b00;
            r_tmo       <= '0;
            r_rdata     <= 32'h0;
            r_mem_addr  <= 32'h0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 32'h0;
            r_mem_wstrb <= 4'b0000;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (lsu_req_valid) begin
                        r_write  <= lsu_req_write;
                        r_funct3 <= lsu_funct3;
                        r_lane   <= lsu_addr[1:0];
                        r_tmo    <= '0;
                        if (w_illegal) begin
                            r_err_code <= c_ERR_FUNCT3;
                        end else if (w_misaligned) begin
                            r_err_code <= c_ERR_MISALIGN;
                        end else begin
                            // Bus fields stay frozen for the whole REQ phase.
                            r_mem_addr  <= {lsu_addr[31:2], 2'b00};
                            r_mem_we    <= lsu_req_write;
                            r_mem_wdata <= w_st_wdata;
                            r_mem_wstrb <= lsu_req_write ? w_st_wstrb : 4'b0000;
                        end
                    end
                end
                S_REQ, S_WAIT: begin
                    r_tmo <= r_tmo + c_TMO_W'(1);
                    if (w_next_state == S_ERR) begin
                        r_err_code <= c_ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
            if ((r_state == S_WAIT) && mem_rvalid && !r_write) begin
                r_rdata <= w_load_fmt;
            end
        end
    end

    assign lsu_ready    = (r_state == S_IDLE);
    assign lsu_done     = (r_state == S_RESP) || (r_state == S_ERR);
    assign lsu_error    = (r_state == S_ERR);
    assign lsu_err_code = (r_state == S_ERR) ? r_err_code : 2'b00;
    assign lsu_rdata    = r_rdata;
    assign mem_req      = (r_state == S_REQ);
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_wstrb    = r_mem_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               behavioural access model and per-cycle output comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_req_valid;
    logic        lsu_req_write;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_ready;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_error;
    logic [1:0]  lsu_err_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    // Model expectations for the access in flight
    bit          chk_en    = 1'b0;
    bit          in_flight = 1'b0;
    logic [1:0]  m_code;
    bit          m_nobus;
    logic [31:0] m_rdata;
    logic [31:0] m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;

    // Values captured by the driver for literal checks
    int          req_cycles;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_we;
    logic [1:0]  cap_code;
    logic        cap_error;
    logic        cap_req_at_done;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_write(lsu_req_write),
        .lsu_funct3   (lsu_funct3),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_ready    (lsu_ready),
        .lsu_done     (lsu_done),
        .lsu_rdata    (lsu_rdata),
        .lsu_error    (lsu_error),
        .lsu_err_code (lsu_err_code),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Access size in bytes, 0 when the funct3/direction pair is not legal.
    function automatic int acc_size(input bit w, input logic [2:0] f3);
        case (f3)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b010:  return 4;
            3'b100:  return w ? 0 : 1;
            3'b101:  return w ? 0 : 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] model_code(input bit w, input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = acc_size(w, f3);
        if (n == 0) return 2'b10;
        if ((int'(a[1:0]) % n) != 0) return 2'b01;
        return 2'b00;
    endfunction

    // Returns {wstrb, wdata}: every bus byte lane carries the store byte of the same rank within the item.
    function automatic logic [35:0] model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n;
        int base;
        logic [31:0] wd;
        logic [3:0]  st;
        n    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        base = (int'(a[1:0]) / n) * n;
        wd   = '0;
        st   = '0;
        for (int lane = 0; lane < 4; lane++) begin
            wd[8*lane +: 8] = d[8*(lane % n) +: 8];
            st[lane]        = (lane >= base) && (lane < base + n);
        end
        return {st, wd};
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int     n;
        bit     sgn;
        int     sh;
        longint v;
        case (f3)
            3'b000:  begin n = 1; sgn = 1'b1; end
            3'b001:  begin n = 2; sgn = 1'b1; end
            3'b100:  begin n = 1; sgn = 1'b0; end
            3'b101:  begin n = 2; sgn = 1'b0; end
            default: begin n = 4; sgn = 1'b0; end
        endcase
        sh = 8 * ((int'(a[1:0]) / n) * n);
        v  = longint'({32'h0, w >> sh}) % (longint'(1) << (8 * n));
        if (sgn && (v >= (longint'(1) << (8 * n - 1)))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // One core access with a scripted memory: grant after gdly request cycles,
    // rvalid rdly cycles after grant (negative = never).
    task automatic access(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input int gdly, input int rdly, input logic [31:0] rd);
        int          cyc;
        int          lat;
        int          req_cnt;
        int          wcnt;
        bit          granted;
        bit          done_seen;
        logic [1:0]  code;
        logic [35:0] st;
        code    = model_code(w, f3, a);
        m_nobus = (code != 2'b00);
        st      = model_store(f3, a, wd);
        m_addr  = {a[31:2], 2'b00};
        m_we    = w;
        m_wdata = st[31:0];
        m_wstrb = w ? st[35:32] : 4'b0000;
        if (m_nobus) lat = 1;
        else if (gdly < 0 || gdly + 1 > TMO) begin code = 2'b11; lat = TMO + 1; end
        else if (rdly < 0 || gdly + 1 + rdly > TMO) begin code = 2'b11; lat = TMO + 1; end
        else lat = gdly + rdly + 2;
        m_code = code;
        if (code == 2'b00 && !w) m_rdata = model_load(f3, a, rd);

        lsu_req_valid = 1'b1;
        lsu_req_write = w;
        lsu_funct3    = f3;
        lsu_addr      = a;
        lsu_wdata     = wd;
        @(posedge clk); #1;
        in_flight  = 1'b1;
        cyc        = 1;
        req_cnt    = 0;
        wcnt       = 0;
        granted    = 1'b0;
        done_seen  = 1'b0;
        req_cycles = 0;
        while (!done_seen && cyc < 64) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A_5A5A;
            if (lsu_done) begin
                done_seen       = 1'b1;
                cap_code        = lsu_err_code;
                cap_error       = lsu_error;
                cap_req_at_done = mem_req;
            end else begin
                if (mem_req) begin
                    req_cnt++;
                    req_cycles++;
                    if (req_cnt == 1) begin
                        cap_addr  = mem_addr;
                        cap_wdata = mem_wdata;
                        cap_wstrb = mem_wstrb;
                        cap_we    = mem_we;
                    end
                    if (gdly >= 0 && req_cnt == gdly + 1) begin
                        mem_gnt = 1'b1;
                        granted = 1'b1;
                    end
                end else if (granted) begin
                    wcnt++;
                    if (rdly >= 0 && wcnt == rdly) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rd;
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("latency", cyc, lat);
        @(posedge clk); #1;
        in_flight     = 1'b0;
        lsu_req_valid = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        lsu_req_valid = 1'b0;
        lsu_req_write = 1'b0;
        lsu_funct3    = 3'b000;
        lsu_addr      = 32'h0;
        lsu_wdata     = 32'h0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 32'h0;
        m_rdata       = 32'h0;
        m_code        = 2'b00;
        m_nobus       = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    if (!in_flight) begin
                        chk("idle_ready", lsu_ready, 1);
                        chk("idle_done", lsu_done, 0);
                        chk("idle_req", mem_req, 0);
                    end else begin
                        chk("busy_ready", lsu_ready, 0);
                        if (mem_req) begin
                            if (m_nobus) chk("req_on_error", mem_req, 0);
                            chk("mem_addr", mem_addr, m_addr);
                            chk("mem_we", mem_we, m_we);
                            chk("mem_wstrb", mem_wstrb, m_wstrb);
                            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
                        end
                        if (lsu_done) begin
                            chk("done_error", lsu_error, (m_code != 2'b00));
                            chk("done_code", lsu_err_code, m_code);
                            chk("done_rdata", lsu_rdata, m_rdata);
                        end
                    end
                end
            end
        join_none

        #1;
        chk("rst_ready", lsu_ready, 1);
        chk("rst_done", lsu_done, 0);
        chk("rst_rdata", lsu_rdata, 0);
        chk("rst_error", lsu_error, 0);
        chk("rst_code", lsu_err_code, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        @(posedge clk); #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // Loads, minimum latency
        access(1'b0, 3'b010, 32'h10, 32'h0, 0, 1, 32'hDEAD_BEEF);
        chk("lw_addr", cap_addr, 32'h10);
        chk("lw_wstrb", cap_wstrb, 4'b0000);
        chk("lw_rdata", lsu_rdata, 32'hDEAD_BEEF);
        access(1'b0, 3'b000, 32'h13, 32'h0, 0, 1, 32'h80FF_0000);
        chk("lb_rdata", lsu_rdata, 32'hFFFF_FF80);
        access(1'b0, 3'b100, 32'h13, 32'h0, 0, 1, 32'h80FF_0000);
        chk("lbu_rdata", lsu_rdata, 32'h0000_0080);
        access(1'b0, 3'b001, 32'h12, 32'h0, 1, 2, 32'h80FF_0000);
        chk("lh_rdata", lsu_rdata, 32'hFFFF_80FF);
        access(1'b0, 3'b101, 32'h12, 32'h0, 0, 1, 32'h80FF_0000);
        chk("lhu_rdata", lsu_rdata, 32'h0000_80FF);
        access(1'b0, 3'b000, 32'h20, 32'h0, 0, 1, 32'h1234_5678);

        // Stores
        access(1'b1, 3'b000, 32'h21, 32'h1234_56AB, 0, 1, 32'h0);
        chk("sb_wdata", cap_wdata, 32'hABAB_ABAB);
        chk("sb_wstrb", cap_wstrb, 4'b0010);
        chk("sb_we", cap_we, 1);
        chk("sb_keeps_rdata", lsu_rdata, 32'h0000_0078);
        access(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 0, 1, 32'h0);
        chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        chk("sh_wstrb", cap_wstrb, 4'b1100);
        access(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, 2, 3, 32'h0);
        chk("sw_wstrb", cap_wstrb, 4'b1111);

        // Errors: no bus activity, done one cycle after accept
        access(1'b0, 3'b010, 32'h6, 32'h0, 0, 1, 32'h0);
        chk("misalign_code", cap_code, 2'b01);
        chk("misalign_req_cycles", req_cycles, 0);
        access(1'b0, 3'b011, 32'h8, 32'h0, 0, 1, 32'h0);
        chk("f3_011_code", cap_code, 2'b10);
        access(1'b1, 3'b100, 32'h8, 32'h0, 0, 1, 32'h0);
        chk("sbu_code", cap_code, 2'b10);
        access(1'b0, 3'b001, 32'h13, 32'h0, 0, 1, 32'h0);
        chk("lh_odd_code", cap_code, 2'b01);

        // Delayed grant, then timeouts
        access(1'b0, 3'b010, 32'h44, 32'h0, 5, 1, 32'h1357_9BDF);
        chk("gnt5_req_cycles", req_cycles, 6);
        chk("gnt5_rdata", lsu_rdata, 32'h1357_9BDF);
        access(1'b0, 3'b010, 32'h48, 32'h0, -1, 1, 32'h0);
        chk("tmo_code", cap_code, 2'b11);
        chk("tmo_error", cap_error, 1);
        chk("tmo_req_low", cap_req_at_done, 0);
        chk("tmo_req_cycles", req_cycles, TMO);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("late_rvalid_ignored", lsu_rdata, 32'h1357_9BDF);
        access(1'b0, 3'b010, 32'h4C, 32'h0, 0, -1, 32'h0);
        chk("tmo_wait_code", cap_code, 2'b11);

        // Reset while waiting for the response
        chk_en        = 1'b0;
        lsu_req_valid = 1'b1;
        lsu_req_write = 1'b0;
        lsu_funct3    = 3'b010;
        lsu_addr      = 32'h40;
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("pre_rst_ready", lsu_ready, 0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_req", mem_req, 0);
        chk("midrst_ready", lsu_ready, 1);
        chk("midrst_done", lsu_done, 0);
        chk("midrst_rdata", lsu_rdata, 0);
        lsu_req_valid = 1'b0;
        reset         = 1'b0;
        m_rdata       = 32'h0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        access(1'b0, 3'b010, 32'h50, 32'h0, 0, 1, 32'h0BAD_F00D);
        chk("post_rst_rdata", lsu_rdata, 32'h0BAD_F00D);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
